// File: rtl/demux_stream.sv
// demux_stream: 1-to-N packet demultiplexer with valid/ready handshake.
// Each packet from the upstream stream is routed to one downstream channel,
// chosen by Select on the packet's first beat and held until its last beat.
// A single registered output entry is shared by all channels.
//
// Ports:
//   Clk        system clock (rising edge)
//   Reset      synchronous, active-high
//   Select     target channel, sampled on the first beat of a packet
//   Data_in    input beat
//   Valid_in   input beat valid
//   Last_in    input beat is the last of its packet
//   Ready_out  upstream may transfer (combinational)
//   Data_out   flat bus, channel k = [k*DATA_W +: DATA_W], all slices identical
//   Valid_out  one-hot (or zero) valid per channel
//   Last_out   last flag per channel, qualified by Valid_out
//   Ready_in   per-channel downstream ready
//   Err_out    one-cycle pulse when a packet is dropped (Select >= N_OUT)
module demux_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [SEL_W-1:0]        Select,
  input  logic [DATA_W-1:0]       Data_in,
  input  logic                    Valid_in,
  input  logic                    Last_in,
  output logic                    Ready_out,
  output logic [N_OUT*DATA_W-1:0] Data_out,
  output logic [N_OUT-1:0]        Valid_out,
  output logic [N_OUT-1:0]        Last_out,
  input  logic [N_OUT-1:0]        Ready_in,
  output logic                    Err_out
);

  localparam int unsigned NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0] NOUT_L = (SEL_W+1)'(N_OUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [N_OUT-1:0]    vld_q, vld_d;
  logic [N_OUT-1:0]    last_q, last_d;
  logic                err_q, err_d;

  logic [NSEL-1:0]     rdy_pad;
  logic                out_vld;
  logic                drn;
  logic                sel_ok;
  logic                rdy;
  logic                acc;
  logic                load;
  logic [SEL_W-1:0]    load_ch;

  // Pad Ready_in to the full Select range so indexing never leaves the vector
  assign rdy_pad = NSEL'(Ready_in);
  assign out_vld = |vld_q;
  assign drn     = out_vld & rdy_pad[out_ch_q];
  assign sel_ok  = ({1'b0, Select} < NOUT_L);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc && !Last_in) begin
          state_d = sel_ok ? ST_ROUTE : ST_DROP;
        end
      end
      ST_ROUTE, ST_DROP: begin
        if (acc && Last_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and output-register next values
  always_comb begin
    rdy      = 1'b0;
    acc      = 1'b0;
    load     = 1'b0;
    load_ch  = cur_ch_q;
    err_d    = 1'b0;
    cur_ch_d = cur_ch_q;
    out_ch_d = out_ch_q;
    data_d   = data_q;
    vld_d    = vld_q;
    last_d   = last_q;

    // A dropping packet never waits on the output entry
    rdy = (state_q == ST_DROP) ? 1'b1 : (!out_vld || rdy_pad[out_ch_q]);
    acc = Valid_in & rdy;

    unique case (state_q)
      ST_IDLE: begin
        load_ch = Select;
        load    = acc & sel_ok;
        err_d   = acc & !sel_ok;
        if (acc) begin
          cur_ch_d = Select;
        end
      end
      ST_ROUTE: begin
        load = acc;
      end
      default: begin
        load = 1'b0;
      end
    endcase

    // Load wins over drain: a same-cycle drain+load just replaces the entry
    if (load) begin
      out_ch_d = load_ch;
      data_d   = Data_in;
      vld_d    = N_OUT'(1) << load_ch;
      last_d   = Last_in ? (N_OUT'(1) << load_ch) : '0;
    end else if (drn) begin
      vld_d  = '0;
      last_d = '0;
    end

    Ready_out = rdy;
  end

  // Output entry and routing registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_ch_q <= '0;
      out_ch_q <= '0;
      data_q   <= '0;
      vld_q    <= '0;
      last_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      out_ch_q <= out_ch_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign Data_out  = {N_OUT{data_q}};
  assign Valid_out = vld_q;
  assign Last_out  = last_q;
  assign Err_out   = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed testbench for demux_stream: a 4-channel instance for the main
// routing scenarios and a 3-channel instance for the drop/error path.
module tb_demux_stream;

  logic        Clk;
  logic        Reset;
  logic [1:0]  sel;
  logic [7:0]  din;
  logic        vin;
  logic        lin;
  logic [3:0]  rdy;

  logic        ro4;
  logic [31:0] dout4;
  logic [3:0]  vo4;
  logic [3:0]  lo4;
  logic        err4;

  logic        ro3;
  logic [23:0] dout3;
  logic [2:0]  vo3;
  logic [2:0]  lo3;
  logic        err3;

  int checks;
  int failures;

  demux_stream #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) dut4 (
    .Clk(Clk), .Reset(Reset), .Select(sel), .Data_in(din), .Valid_in(vin),
    .Last_in(lin), .Ready_out(ro4), .Data_out(dout4), .Valid_out(vo4),
    .Last_out(lo4), .Ready_in(rdy), .Err_out(err4)
  );

  demux_stream #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) dut3 (
    .Clk(Clk), .Reset(Reset), .Select(sel), .Data_in(din), .Valid_in(vin),
    .Last_in(lin), .Ready_out(ro3), .Data_out(dout3), .Valid_out(vo3),
    .Last_out(lo3), .Ready_in(rdy[2:0]), .Err_out(err3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic [1:0] s, input logic [7:0] d,
                       input logic v, input logic l);
    sel = s; din = d; vin = v; lin = l;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    drive(2'd0, 8'h00, 1'b0, 1'b0);
    rdy = 4'hF;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(2'd0, 8'h00, 1'b0, 1'b0);
    rdy = 4'hF;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (vo4 !== 4'b0 || lo4 !== 4'b0 || dout4 !== 32'h0 || err4 !== 1'b0) begin
      failures++;
      $display("FAIL reset4 got vld=%b last=%b data=%h err=%b exp all zero", vo4, lo4, dout4, err4);
    end
    checks++;
    if (vo3 !== 3'b0 || lo3 !== 3'b0 || dout3 !== 24'h0 || err3 !== 1'b0) begin
      failures++;
      $display("FAIL reset3 got vld=%b last=%b data=%h err=%b exp all zero", vo3, lo3, dout3, err3);
    end
    checks++;
    if (ro4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b exp 1", ro4);
    end
    Reset = 1'b0;
  endtask

  // Sel=2, 3-beat packet AA,BB,CC
  task automatic test_basic();
    logic [1:0] s  [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [7:0] d  [5] = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
    logic       v  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       l  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] ev [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [7:0] ed [5] = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    logic [3:0] el [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    rdy = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (vo4 !== ev[i] || lo4 !== el[i]) begin
        failures++;
        $display("FAIL basic_vld cyc%0d got vld=%b last=%b exp vld=%b last=%b", i, vo4, lo4, ev[i], el[i]);
      end
      if (ev[i] != 4'b0) begin
        checks++;
        if (dout4 !== {4{ed[i]}}) begin
          failures++;
          $display("FAIL basic_data cyc%0d got %h exp %h", i, dout4, {4{ed[i]}});
        end
      end
      drive(s[i], d[i], v[i], l[i]);
      #1;
      if (v[i]) begin
        checks++;
        if (ro4 !== 1'b1) begin
          failures++;
          $display("FAIL basic_ready cyc%0d got %b exp 1", i, ro4);
        end
      end
    end
  endtask

  // Select changes mid-packet; next packet uses the new Select
  task automatic test_sel_hold();
    logic [1:0] s  [6] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [7:0] d  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    logic       v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       l  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] ev [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
    logic [7:0] ed [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    logic [3:0] el [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0000};
    rdy = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      checks++;
      if (vo4 !== ev[i] || lo4 !== el[i]) begin
        failures++;
        $display("FAIL selhold_vld cyc%0d got vld=%b last=%b exp vld=%b last=%b", i, vo4, lo4, ev[i], el[i]);
      end
      if (ev[i] != 4'b0) begin
        checks++;
        if (dout4 !== {4{ed[i]}}) begin
          failures++;
          $display("FAIL selhold_data cyc%0d got %h exp %h", i, dout4, {4{ed[i]}});
        end
      end
      drive(s[i], d[i], v[i], l[i]);
    end
  endtask

  // ch1 beat held while Ready_in[1]=0, then drain and load in one cycle
  task automatic test_backpressure();
    rdy = 4'b1101;
    @(negedge Clk);
    drive(2'd1, 8'h55, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      drive(2'd1, 8'h66, 1'b1, 1'b1);
      #1;
      checks++;
      if (vo4 !== 4'b0010 || dout4 !== {4{8'h55}} || ro4 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d got vld=%b data=%h rdy=%b exp vld=0010 data=55 rdy=0", i, vo4, dout4, ro4);
      end
    end
    rdy = 4'hF;
    #1;
    checks++;
    if (ro4 !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got %b exp 1", ro4);
    end
    @(negedge Clk);
    checks++;
    if (vo4 !== 4'b0010 || dout4 !== {4{8'h66}} || lo4 !== 4'b0010) begin
      failures++;
      $display("FAIL bp_next got vld=%b data=%h last=%b exp vld=0010 data=66 last=0010", vo4, dout4, lo4);
    end
    drive(2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if (vo4 !== 4'b0000) begin
      failures++;
      $display("FAIL bp_empty got vld=%b exp 0000", vo4);
    end
  endtask

  // Back-to-back single-beat packets to ch0, ch3, ch1
  task automatic test_back_to_back();
    logic [1:0] s  [4] = '{2'd0, 2'd3, 2'd1, 2'd0};
    logic [7:0] d  [4] = '{8'hA0, 8'hA3, 8'hA1, 8'h00};
    logic       v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ev [5] = '{4'b0000, 4'b0001, 4'b1000, 4'b0010, 4'b0000};
    logic [7:0] ed [5] = '{8'h00, 8'hA0, 8'hA3, 8'hA1, 8'h00};
    rdy = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (vo4 !== ev[i] || lo4 !== ev[i]) begin
        failures++;
        $display("FAIL b2b_vld cyc%0d got vld=%b last=%b exp %b", i, vo4, lo4, ev[i]);
      end
      if (ev[i] != 4'b0) begin
        checks++;
        if (dout4 !== {4{ed[i]}}) begin
          failures++;
          $display("FAIL b2b_data cyc%0d got %h exp %h", i, dout4, {4{ed[i]}});
        end
      end
      if (i < 4) begin
        drive(s[i], d[i], v[i], v[i]);
        #1;
        if (v[i]) begin
          checks++;
          if (ro4 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready cyc%0d got %b exp 1", i, ro4);
          end
        end
      end
    end
  endtask

  // N_OUT=3: Select=3 packet dropped with one Err pulse, then Sel=1 routes
  task automatic test_drop();
    int err_cnt;
    logic [1:0] s  [4] = '{2'd3, 2'd3, 2'd1, 2'd0};
    logic [7:0] d  [4] = '{8'h77, 8'h88, 8'h99, 8'h00};
    logic       v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       l  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       ee [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] ev [5] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
    err_cnt = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (err3 === 1'b1) err_cnt++;
      checks++;
      if (err3 !== ee[i] || vo3 !== ev[i] || lo3 !== ev[i]) begin
        failures++;
        $display("FAIL drop cyc%0d got err=%b vld=%b last=%b exp err=%b vld=%b last=%b",
                 i, err3, vo3, lo3, ee[i], ev[i], ev[i]);
      end
      if (ev[i] != 3'b0) begin
        checks++;
        if (dout3 !== {3{8'h99}}) begin
          failures++;
          $display("FAIL drop_data got %h exp %h", dout3, {3{8'h99}});
        end
      end
      if (i < 4) begin
        drive(s[i], d[i], v[i], l[i]);
        #1;
        if (v[i]) begin
          checks++;
          if (ro3 !== 1'b1) begin
            failures++;
            $display("FAIL drop_ready cyc%0d got %b exp 1", i, ro3);
          end
        end
      end
    end
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL drop_err_count got %0d exp 1", err_cnt);
    end
  endtask

  // Reset while a ch2 beat is held mid-packet
  task automatic test_reset_mid();
    apply_reset();
    rdy = 4'b1011;
    @(negedge Clk);
    drive(2'd2, 8'hC1, 1'b1, 1'b0);
    @(negedge Clk);
    drive(2'd2, 8'hC2, 1'b1, 1'b0);
    #1;
    checks++;
    if (vo4 !== 4'b0100 || ro4 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre got vld=%b rdy=%b exp vld=0100 rdy=0", vo4, ro4);
    end
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (vo4 !== 4'b0 || lo4 !== 4'b0 || dout4 !== 32'h0 || err4 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear got vld=%b last=%b data=%h err=%b exp all zero", vo4, lo4, dout4, err4);
    end
    Reset = 1'b0;
    rdy = 4'hF;
    drive(2'd0, 8'hD0, 1'b1, 1'b1);
    @(negedge Clk);
    checks++;
    if (vo4 !== 4'b0001 || lo4 !== 4'b0001 || dout4 !== {4{8'hD0}}) begin
      failures++;
      $display("FAIL rstmid_route got vld=%b last=%b data=%h exp vld=0001 last=0001 data=d0d0d0d0",
               vo4, lo4, dout4);
    end
    drive(2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if (vo4 !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_empty got vld=%b exp 0000", vo4);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_sel_hold();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
